// File: rtl/uart_tx_packetizer.sv
// Packet builder in front of a DV/Active/Done byte UART transmitter: frames a command,
// length and payload as SYNC, CMD, LEN, payload..., CHECKSUM and hands them over one byte at a time.
module uart_tx_packetizer #(
  parameter int unsigned MAX_BYTES   = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Frame_Valid,
  output logic                   o_Frame_Ready,
  input  logic [7:0]             i_Cmd,
  input  logic [3:0]             i_Len,
  input  logic [8*MAX_BYTES-1:0] i_Payload,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Busy,
  output logic                   o_Frame_Done,
  output logic                   o_Err
);

  localparam int unsigned        IDX_W    = 5;
  localparam int unsigned        CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0]         MAX_LEN  = 4'(MAX_BYTES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACTIVE,
    WAIT_DONE,
    WAIT_CLR
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             csum_q, csum_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [3:0]             len_q, len_d;
  logic [8*MAX_BYTES-1:0] payload_q, payload_d;
  logic                   tx_dv_q, tx_dv_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic [IDX_W-1:0]       last_idx;

  // Byte at a given packet position; the checksum slot returns the running sum so far.
  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0]       idx,
                                         input logic [7:0]             cmd,
                                         input logic [3:0]             len,
                                         input logic [8*MAX_BYTES-1:0] pl,
                                         input logic [7:0]             csum);
    logic [7:0]       b;
    logic [IDX_W-1:0] last;
    last = IDX_W'(len) + IDX_W'(3);
    b    = csum;
    if (idx == IDX_W'(0)) begin
      b = SYNC_BYTE;
    end else if (idx == IDX_W'(1)) begin
      b = cmd;
    end else if (idx == IDX_W'(2)) begin
      b = {4'h0, len};
    end else if (idx != last) begin
      for (int k = 0; k < int'(MAX_BYTES); k++) begin
        if (idx == IDX_W'(k + 3)) b = pl[8*k +: 8];
      end
    end
    return b;
  endfunction

  // The transmitter has no reset, so a frame may only start once it has fully drained.
  assign o_Frame_Ready = (state_q == IDLE) & ~i_Tx_Active & ~i_Tx_Done;
  assign accept        = i_Frame_Valid & o_Frame_Ready;
  assign last_idx      = IDX_W'(len_q) + IDX_W'(3);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    len_d        = len_q;
    payload_d    = payload_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_Len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            cmd_d     = i_Cmd;
            len_d     = i_Len;
            payload_d = i_Payload;
            idx_d     = '0;
            csum_d    = '0;
            cnt_d     = CNT_W'(1);
            tx_dv_d   = 1'b1;
            tx_byte_d = SYNC_BYTE;
            busy_d    = 1'b1;
            state_d   = ISSUE;
          end
        end
      end

      ISSUE: state_d = WAIT_ACTIVE;

      WAIT_ACTIVE: begin
        if (i_Tx_Active) begin
          state_d = WAIT_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (i_Tx_Done) state_d = WAIT_CLR;
      end

      // Done may stay high for two clocks; wait for it to fall so each byte counts once.
      WAIT_CLR: begin
        if (!i_Tx_Done && !i_Tx_Active) begin
          if (idx_q < last_idx) begin
            idx_d     = idx_q + IDX_W'(1);
            tx_byte_d = byte_at(idx_d, cmd_q, len_q, payload_q, csum_q);
            if (idx_d < last_idx) csum_d = csum_q + tx_byte_d;
            cnt_d     = CNT_W'(1);
            tx_dv_d   = 1'b1;
            state_d   = ISSUE;
          end else begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      csum_q       <= '0;
      cnt_q        <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      cnt_q        <= cnt_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
    cmd_q     <= cmd_d;
    len_q     <= len_d;
    payload_q <= payload_d;
  end

  assign o_Tx_DV      = tx_dv_q;
  assign o_Tx_Byte    = tx_byte_q;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = frame_done_q;
  assign o_Err        = err_q;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Bench for uart_tx_packetizer: behavioural byte-transmitter stub, event monitor and a
// packet reference model built directly from command, length and payload.
module tb_uart_tx_packetizer;

  localparam int         MAX_BYTES   = 8;
  localparam int         ACK_TIMEOUT = 16;
  localparam logic [7:0] SYNC        = 8'hAA;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   frame_valid;
  logic                   frame_ready;
  logic [7:0]             cmd;
  logic [3:0]             len;
  logic [8*MAX_BYTES-1:0] payload;
  logic                   tx_dv;
  logic [7:0]             tx_byte;
  logic                   tx_active;
  logic                   tx_done;
  logic                   busy;
  logic                   frame_done;
  logic                   err;

  always #5 clk = ~clk;

  uart_tx_packetizer #(
    .MAX_BYTES  (MAX_BYTES),
    .SYNC_BYTE  (SYNC),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Frame_Valid(frame_valid),
    .o_Frame_Ready(frame_ready),
    .i_Cmd        (cmd),
    .i_Len        (len),
    .i_Payload    (payload),
    .o_Tx_DV      (tx_dv),
    .o_Tx_Byte    (tx_byte),
    .i_Tx_Active  (tx_active),
    .i_Tx_Done    (tx_done),
    .o_Busy       (busy),
    .o_Frame_Done (frame_done),
    .o_Err        (err)
  );

  int checks = 0;
  int errors = 0;

  bit stub_en   = 1'b1;
  bit stub_mute = 1'b0;
  int act_dly   = 0;
  int busy_len  = 3;
  int done_len  = 1;
  logic [7:0] seen_q[$];

  int   cyc      = 0;
  int   dv_cnt   = 0;
  int   fd_cnt   = 0;
  int   err_cnt  = 0;
  int   dv_cyc   = 0;
  int   err_cyc  = 0;
  int   viol_cnt = 0;
  int   both_cnt = 0;
  logic prev_active = 1'b0;
  logic prev_done   = 1'b0;

  // Transmitter stub: drives Active/Done 1 time unit after the clock edge.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stub_en && tx_dv === 1'b1) begin
        seen_q.push_back(tx_byte);
        if (!stub_mute) begin
          repeat (act_dly) begin @(posedge clk); #1; end
          tx_active = 1'b1;
          repeat (busy_len) begin @(posedge clk); #1; end
          tx_active = 1'b0;
          tx_done   = 1'b1;
          repeat (done_len) begin @(posedge clk); #1; end
          tx_done = 1'b0;
        end
      end
    end
  end

  // Event monitor: counts pulses; prev_* hold the transmitter status seen at the current edge.
  initial begin
    forever begin
      @(posedge clk); #3;
      cyc++;
      if (tx_dv === 1'b1) begin
        dv_cnt++;
        dv_cyc = cyc;
        if (prev_active || prev_done) viol_cnt++;
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (err === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (frame_done === 1'b1 && err === 1'b1) both_cnt++;
      prev_active = tx_active;
      prev_done   = tx_done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] last_seen();
    if (seen_q.size() == 0) return 32'hFFFF_FFFF;
    return 32'(seen_q[seen_q.size()-1]);
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (frame_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(frame_ready), 32'd1);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] c, input logic [3:0] l,
                            input logic [8*MAX_BYTES-1:0] p, input int hold);
    logic [7:0] exp_q[$];
    int         sum, dv0, fd0, er0, n;
    bit         busy_ok;
    exp_q.push_back(SYNC);
    exp_q.push_back(c);
    exp_q.push_back({4'h0, l});
    sum = int'(c) + int'(l);
    for (int k = 0; k < int'(l); k++) begin
      exp_q.push_back(p[8*k +: 8]);
      sum += int'(p[8*k +: 8]);
    end
    exp_q.push_back(8'(sum % 256));

    wait_ready(tag);
    seen_q.delete();
    dv0 = dv_cnt; fd0 = fd_cnt; er0 = err_cnt;
    frame_valid = 1'b1; cmd = c; len = l; payload = p;
    @(negedge clk);
    busy_ok = 1'b1;
    n = 0;
    while (fd_cnt == fd0 && err_cnt == er0 && n < 5000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      frame_valid = (n < hold);
      cmd     = 8'($urandom);
      len     = 4'($urandom_range(0, MAX_BYTES));
      payload = {$urandom, $urandom};
      @(negedge clk);
      n++;
    end
    frame_valid = 1'b0;
    chk({tag, " completes"}, 32'(n < 5000), 32'd1);
    chk({tag, " frame_done pulses"}, 32'(fd_cnt - fd0), 32'd1);
    chk({tag, " no err"}, 32'(err_cnt - er0), 32'd0);
    chk({tag, " busy throughout"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy cleared"}, 32'(busy), 32'd0);
    chk({tag, " dv count"}, 32'(dv_cnt - dv0), 32'(exp_q.size()));
    chk({tag, " byte count"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i),
          (i < seen_q.size()) ? 32'(seen_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    repeat (3) @(negedge clk);
    chk({tag, " no extra dv"}, 32'(dv_cnt - dv0), 32'(exp_q.size()));
  endtask

  initial begin
    int  dv0, fd0, er0, n;
    bit  ready_bad;
    rst_n = 1'b0; frame_valid = 1'b0; cmd = '0; len = '0; payload = '0;
    repeat (3) @(negedge clk);
    chk("reset tx_dv", 32'(tx_dv), 32'd0);
    chk("reset tx_byte", 32'(tx_byte), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset ready", 32'(frame_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame("basic", 8'h10, 4'd2, 64'h1234, 0);
    chk("basic checksum", last_seen(), 32'h58);
    send_frame("zero len", 8'hFF, 4'd0, 64'h0, 0);
    chk("zero len checksum", last_seen(), 32'hFF);
    send_frame("wrap", 8'h80, 4'd1, 64'h90, 0);
    chk("wrap checksum", last_seen(), 32'h11);
    send_frame("full", 8'h00, 4'd8, 64'h0807060504030201, 0);
    chk("full checksum", last_seen(), 32'h2C);

    // Two-cycle Done and slow Active from the transmitter.
    act_dly = 2; done_len = 2;
    send_frame("slow tx", 8'h5A, 4'd3, 64'hC0FFEE, 0);
    act_dly = 0; done_len = 1;

    // Valid held high with different data while the frame is in flight.
    busy_len = 5;
    send_frame("valid while busy", 8'hC3, 4'd3, 64'h00A1B2C3, 8);
    busy_len = 3;

    // Oversize length.
    wait_ready("oversize");
    dv0 = dv_cnt; er0 = err_cnt;
    frame_valid = 1'b1; cmd = 8'h55; len = 4'd9;
    @(negedge clk);
    frame_valid = 1'b0;
    chk("oversize err", 32'(err), 32'd1);
    chk("oversize busy", 32'(busy), 32'd0);
    chk("oversize ready", 32'(frame_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("oversize err once", 32'(err_cnt - er0), 32'd1);
    chk("oversize no dv", 32'(dv_cnt - dv0), 32'd0);

    // Transmitter never acknowledges.
    stub_mute = 1'b1;
    wait_ready("timeout");
    seen_q.delete();
    dv0 = dv_cnt; er0 = err_cnt; fd0 = fd_cnt;
    frame_valid = 1'b1; cmd = 8'h42; len = 4'd1; payload = 64'h77;
    @(negedge clk);
    frame_valid = 1'b0;
    n = 0;
    while (err_cnt == er0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout err once", 32'(err_cnt - er0), 32'd1);
    chk("timeout latency", 32'(err_cyc - dv_cyc), 32'(ACK_TIMEOUT));
    chk("timeout busy", 32'(busy), 32'd0);
    chk("timeout dv count", 32'(dv_cnt - dv0), 32'd1);
    chk("timeout first byte", 32'(seen_q.size() > 0 ? seen_q[0] : 8'h00), 32'(SYNC));
    chk("timeout no done", 32'(fd_cnt - fd0), 32'd0);
    @(negedge clk);
    chk("timeout ready", 32'(frame_ready), 32'd1);
    stub_mute = 1'b0;

    // Reset while a payload byte is being shifted.
    busy_len = 20; done_len = 2;
    wait_ready("reset mid");
    dv0 = dv_cnt; er0 = err_cnt; fd0 = fd_cnt;
    frame_valid = 1'b1; cmd = 8'h33; len = 4'd8; payload = {$urandom, $urandom};
    @(negedge clk);
    frame_valid = 1'b0;
    n = 0;
    while (dv_cnt - dv0 < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset mid busy", 32'(busy), 32'd0);
    chk("reset mid tx_dv", 32'(tx_dv), 32'd0);
    chk("reset mid ready held", 32'(frame_ready), 32'd0);
    ready_bad = 1'b0;
    n = 0;
    while (frame_ready !== 1'b1 && n < 200) begin
      if (frame_ready !== (!tx_active && !tx_done)) ready_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("reset mid ready returns", 32'(frame_ready), 32'd1);
    chk("reset mid ready tracks tx", 32'(ready_bad), 32'd0);
    chk("reset mid tx idle", 32'(tx_active | tx_done), 32'd0);
    chk("reset mid no done", 32'(fd_cnt - fd0), 32'd0);
    chk("reset mid no err", 32'(err_cnt - er0), 32'd0);
    busy_len = 3; done_len = 1;
    send_frame("after reset", 8'h21, 4'd4, 64'hDEADBEEF, 0);

    // Randomized frames with randomized transmitter timing.
    for (int f = 0; f < 12; f++) begin
      act_dly  = int'($urandom_range(0, 3));
      busy_len = int'($urandom_range(1, 6));
      done_len = int'($urandom_range(1, 2));
      send_frame($sformatf("rand%0d", f), 8'($urandom), 4'($urandom_range(0, MAX_BYTES)),
                 {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    chk("dv while tx busy", 32'(viol_cnt), 32'd0);
    chk("err with frame_done", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
